// File: rtl/mult8_seq_ctrl_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
package mult8_seq_ctrl_pkg;

  localparam int unsigned OPW   = 8;
  localparam int unsigned NIBW  = 4;
  localparam int unsigned PRODW = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StStep = 2'd1,
    StDone = 2'd2
  } state_e;

  // Left shift applied to the partial product of step k (index = k).
  localparam logic [3:0][3:0] StepShift = {4'd8, 4'd4, 4'd4, 4'd0};

endpackage

// File: rtl/wallace_Multiplier.sv
// 4x4 unsigned combinational multiplier: partial-product rows reduced by adders.
module wallace_Multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product
);

  logic [7:0] row0, row1, row2, row3;

  // Gate each shifted multiplicand row by one multiplier bit, then sum.
  always_comb begin
    row0    = b[0] ? {4'b0000, a}        : 8'h00;
    row1    = b[1] ? {3'b000, a, 1'b0}   : 8'h00;
    row2    = b[2] ? {2'b00, a, 2'b00}   : 8'h00;
    row3    = b[3] ? {1'b0, a, 3'b000}   : 8'h00;
    product = (row0 + row1) + (row2 + row3);
  end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 multiplier: one 4x4 multiplier time-shared over four steps.
// Optional macro MULT_SIGNED_EN adds the sgn port for two's-complement operands.
module mult8_seq_ctrl
  import mult8_seq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PRODW-1:0] product,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [1:0]       k_q;
  logic [OPW-1:0]   a_q, b_q;
  logic [PRODW-1:0] acc_q;
  logic             neg_q;

  logic             accept;
  logic [OPW-1:0]   a_in, b_in;
  logic             neg_in;
  logic [NIBW-1:0]  nib_a, nib_b;
  logic [7:0]       pp;
  logic [PRODW-1:0] pp_sh;

  // Operand conditioning at acceptance: magnitudes plus result sign when signed.
`ifdef MULT_SIGNED_EN
  always_comb begin
    a_in   = (sgn && a[OPW-1]) ? (~a + 8'd1) : a;
    b_in   = (sgn && b[OPW-1]) ? (~b + 8'd1) : b;
    neg_in = sgn & (a[OPW-1] ^ b[OPW-1]);
  end
`else
  always_comb begin
    a_in   = a;
    b_in   = b;
    neg_in = 1'b0;
  end
`endif

  assign accept = in_valid && in_ready;

  // Nibble selection in front of the shared 4x4 multiplier.
  always_comb begin
    nib_a = a_q[3:0];
    nib_b = b_q[3:0];
    unique case (k_q)
      2'd0: begin nib_a = a_q[3:0]; nib_b = b_q[3:0]; end
      2'd1: begin nib_a = a_q[7:4]; nib_b = b_q[3:0]; end
      2'd2: begin nib_a = a_q[3:0]; nib_b = b_q[7:4]; end
      2'd3: begin nib_a = a_q[7:4]; nib_b = b_q[7:4]; end
      default: ;
    endcase
  end

  wallace_Multiplier u_mult (
    .a       (nib_a),
    .b       (nib_b),
    .product (pp)
  );

  assign pp_sh = {8'h00, pp} << StepShift[k_q];

  // Next-state logic and outputs decoded from the current state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    product   = '0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StStep;
      end
      StStep: begin
        if (k_q == 2'd3) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        product   = neg_q ? (~acc_q + 16'd1) : acc_q;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Datapath: capture operands on acceptance, accumulate one partial product per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= 2'd0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
    end else if (accept) begin
      k_q   <= 2'd0;
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= '0;
      neg_q <= neg_in;
    end else if (state_q == StStep) begin
      k_q   <= k_q + 2'd1;
      acc_q <= acc_q + pp_sh;
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed self-checking bench for mult8_seq_ctrl.
module tb_mult8_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mult8_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef MULT_SIGNED_EN
    .sgn       (sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // One full transaction with out_ready held high; optional operand scramble after acceptance.
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic s, input logic [15:0] exp, input bit scramble);
    chk({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    sgn = s;
    tick();  // cycle T+1: first step
    in_valid = 1'b0;
    if (scramble) begin
      a = 8'h00;
      b = 8'h00;
      sgn = 1'b0;
    end
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    chk({tag, " in_ready step"}, {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    tick();  // cycle T+4: last step
    chk({tag, " early valid"}, {15'd0, out_valid, product}, 32'd0);
    tick();  // cycle T+5
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " product"}, {16'd0, product}, {16'd0, exp});
    tick();
    chk({tag, " back idle"}, {29'd0, in_ready, out_valid, busy}, 32'd4);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    sgn = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("reset outputs", {13'd0, in_ready, out_valid, busy, product}, 32'h0004_0000);
    rst = 1'b0;
    tick();

    run_op("ff*ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0);
    run_op("12*34", 8'h12, 8'h34, 1'b0, 16'h03A8, 1'b0);
    run_op("0f*f0", 8'h0F, 8'hF0, 1'b0, 16'h0E10, 1'b0);
    run_op("01*ff", 8'h01, 8'hFF, 1'b0, 16'h00FF, 1'b0);
    run_op("00*ab", 8'h00, 8'hAB, 1'b0, 16'h0000, 1'b0);
    run_op("scramble", 8'h10, 8'h10, 1'b0, 16'h0100, 1'b1);

    // Backpressure: hold product in DONE while in_valid pulses are ignored.
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 8'h12;
    b = 8'h34;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("bp done", {15'd0, out_valid, product}, 32'h0001_03A8);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 1);
      a = 8'h77;
      b = 8'h55;
      tick();
      chk("bp hold", {14'd0, in_ready, out_valid, product}, 32'h0001_03A8);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp handover", {29'd0, in_ready, out_valid, busy}, 32'd4);
    tick();
    chk("bp no restart", {30'd0, busy, out_valid}, 32'd0);

    // Reset during the k=2 step abandons the operation.
    in_valid = 1'b1;
    a = 8'hAB;
    b = 8'hCD;
    tick();  // k=0
    in_valid = 1'b0;
    tick();  // k=1
    tick();  // k=2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst", {13'd0, in_ready, out_valid, busy, product}, 32'h0004_0000);
    repeat (4) tick();
    chk("mid rst quiet", {15'd0, out_valid, product}, 32'd0);
    run_op("03*05", 8'h03, 8'h05, 1'b0, 16'h000F, 1'b0);

`ifdef MULT_SIGNED_EN
    run_op("s ff*ff", 8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0);
    run_op("s 80*7f", 8'h80, 8'h7F, 1'b1, 16'hC080, 1'b0);
    run_op("u 80*02", 8'h80, 8'h02, 1'b0, 16'h0100, 1'b0);
`else
    run_op("80*02", 8'h80, 8'h02, 1'b0, 16'h0100, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult8_seq_ctrl.md
MULT8_SEQ_CTRL -- requirements
Module: mult8_seq_ctrl

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high; the ports SHALL be named clk and rst.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, operand pair offered.
- in_ready, out, 1, block accepts an operand pair.
- a, in, 8, multiplicand.
- b, in, 8, multiplier.
- sgn, in, 1, operands are two's-complement; present only when MULT_SIGNED_EN is defined.
- out_valid, out, 1, product available.
- out_ready, in, 1, consumer accepts the product.
- product, out, 16, result.
- busy, out, 1, an operation is in progress (state not IDLE).

Function
REQ-003 The block SHALL compute an 8x8 product by time-sharing one 4x4 combinational multiplier over four steps.
REQ-004 FSM states SHALL be IDLE, STEP (2-bit step counter k = 0..3) and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; an input is accepted when in_valid and in_ready are both 1; on acceptance, a and b (and sgn) SHALL be registered, the 16-bit accumulator cleared, k=0, and the next state SHALL be STEP.
REQ-006 Each STEP cycle SHALL add one partial product to the accumulator:
- k=0: a[3:0]*b[3:0], shifted by 0.
- k=1: a[7:4]*b[3:0], shifted by 4.
- k=2: a[3:0]*b[7:4], shifted by 4.
- k=3: a[7:4]*b[7:4], shifted by 8.
REQ-007 Accumulation SHALL be 16-bit modulo; no overflow is possible for unsigned operands.
REQ-008 After k=3 the next state SHALL be DONE; out_valid SHALL be 1 exactly in DONE.
REQ-009 Latency: acceptance at cycle T SHALL give out_valid=1 at cycle T+5.
REQ-010 In DONE, product and out_valid SHALL hold stable until out_ready=1; on out_valid and out_ready the next state SHALL be IDLE.
REQ-011 in_valid SHALL be ignored outside IDLE, and a and b changes after acceptance SHALL NOT affect the result.
REQ-012 Throughput SHALL be one product per 6 cycles, or more cycles under backpressure.
REQ-013 product SHALL be 0 whenever out_valid is 0.

Reset
REQ-014 While rst=1 at a clock edge: state SHALL go to IDLE, the accumulator, operand registers and k SHALL be cleared, and the outputs SHALL become in_ready=1, out_valid=0, busy=0, product=0.
REQ-015 Reset asserted mid-operation, in STEP or DONE, SHALL abandon the operation with no output produced.

Configuration
REQ-016 With MULT_SIGNED_EN defined:
- The sgn port SHALL exist.
- If sgn=1 at acceptance, the absolute values of a and b SHALL be registered, along with result sign = a[7]^b[7].
- In DONE, product SHALL be the two's-complement negation of the accumulator when the result sign is 1.
- Latency SHALL be unchanged.
REQ-017 Without MULT_SIGNED_EN, the sgn port SHALL be absent and all operands SHALL be unsigned.

Structure
REQ-018 A shared package SHALL hold:
- The FSM state enum (IDLE, STEP, DONE).
- The constants OPW=8, NIBW=4 and PRODW=16.
- The per-step shift amounts {0,4,4,8}.
REQ-019 The block SHALL instantiate exactly one sub-module, wallace_Multiplier: the codebase's 4x4 combinational multiplier with ports a[3:0], b[3:0] and product[7:0].
REQ-020 Nibble selection SHALL be muxed by k in front of that sub-module.

Verification
REQ-021 a=0xFF, b=0xFF, out_ready=1 -> product=0xFE01 with out_valid at T+5.
REQ-022 a=0x12, b=0x34 -> product=0x03A8.
REQ-023 Hold out_ready=0 for 3 cycles in DONE -> product and out_valid are stable; in_ready=0; pulses on in_valid are ignored; handover completes on the cycle out_ready=1.
REQ-024 rst=1 in the STEP cycle with k=2 -> the next cycle shows in_ready=1, out_valid=0, product=0; a fresh 0x03*0x05 then yields 0x000F.
REQ-025 Change a and b to 0x00 on the cycle after acceptance of 0x10*0x10 -> product=0x0100.
REQ-026 With MULT_SIGNED_EN:
- sgn=1, a=0xFF, b=0xFF -> product=0x0001.
- sgn=1, a=0x80, b=0x7F -> product=0xC080.
- sgn=0, a=0x80, b=0x02 -> product=0x0100.
